// File: rtl/raspi_link_pkg.sv
// Shared constants and RX state encoding for the RasPi parallel link.
// Imported by raspi_link_fifo and raspi_link_endpoint.
package raspi_link_pkg;
  localparam int RASPI_WORD_W = 9;
  localparam logic [8:0] RASPI_ESC = 9'h1ff;
  localparam logic [7:0] RASPI_CMD_RESET = 8'hff;
  localparam logic [7:0] RASPI_CMD_DEBUG = 8'h00;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_FRAME,
    RX_ESC
  } rx_state_e;
endpackage

// File: rtl/raspi_link_fifo.sv
// Synchronous FIFO with flush; one extra pointer bit separates full from empty.
// DEPTH must be a power of two >= 2.
module raspi_link_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full = (wr_ptr[AW] != rd_ptr[AW]) &&
                (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/raspi_link_endpoint.sv
// FPGA endpoint of the 9-bit RasPi link: RX escape/channel decode, TX FIFO.
// Define RASPI_LINK_STATS_EN to add the rx_words/tx_words counters.
module raspi_link_endpoint
  import raspi_link_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    raspi_clk,
  input  logic                    raspi_dir,
  input  logic [RASPI_WORD_W-1:0] raspi_dat_i,
  output logic [RASPI_WORD_W-1:0] raspi_dat_o,
  output logic                    raspi_dat_oe,
  output logic                    rx_valid,
  output logic                    rx_start,
  output logic                    rx_end,
  output logic [7:0]              rx_chan,
  output logic [7:0]              rx_data,
  output logic                    link_reset,
  output logic                    dbg_req,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  input  logic [RASPI_WORD_W-1:0] tx_data
`ifdef RASPI_LINK_STATS_EN
  ,
  output logic [15:0]             rx_words,
  output logic [15:0]             tx_words
`endif
);
  localparam int SW = RASPI_WORD_W + 2;
  localparam logic [SW-1:0] SYNC_RST = {1'b0, 1'b1, {RASPI_WORD_W{1'b0}}};

  // clk, dir and dat travel together so a word is always sampled coherently
  logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
  logic                    s_clk;
  logic                    s_dir;
  logic [RASPI_WORD_W-1:0] s_dat;
  logic                    clk_prev;
  logic                    wr_evt;
  logic                    rd_evt;

  assign {s_clk, s_dir, s_dat} = sync_q[SYNC_STAGES-1];
  assign wr_evt = s_clk && !clk_prev && s_dir;
  assign rd_evt = s_clk && !clk_prev && !s_dir;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= {SYNC_STAGES{SYNC_RST}};
      clk_prev <= 1'b0;
      raspi_dat_oe <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {raspi_clk, raspi_dir, raspi_dat_i}};
      clk_prev <= s_clk;
      raspi_dat_oe <= !s_dir;
    end
  end

  rx_state_e state, state_n;
  logic       pend_start, pend_n;
  logic [7:0] pend_chan, pchan_n;
  logic       start_n, end_n, valid_n, lrst_n, dbg_n;
  logic [7:0] chan_n, data_n;
  logic       is_esc, is_hdr, esc_cmd, frame_dat;

  assign is_esc = (s_dat == RASPI_ESC);
  assign is_hdr = s_dat[8] && !is_esc;
  assign esc_cmd = !s_dat[8] && (state == RX_ESC);
  assign frame_dat = !s_dat[8] && (state == RX_FRAME);

  always_comb begin
    state_n = state;
    pend_n = 1'b0;
    pchan_n = pend_chan;
    start_n = 1'b0;
    end_n = 1'b0;
    valid_n = 1'b0;
    lrst_n = 1'b0;
    dbg_n = 1'b0;
    chan_n = rx_chan;
    data_n = rx_data;
    // deferred rx_start after a channel switch closed the old frame
    if (pend_start) begin
      start_n = 1'b1;
      chan_n = pend_chan;
    end
    if (wr_evt) begin
      unique case (1'b1)
        is_esc: begin
          end_n = (state == RX_FRAME);
          state_n = RX_ESC;
        end
        is_hdr: begin
          if (state == RX_FRAME) begin
            end_n = 1'b1;
            pend_n = 1'b1;
            pchan_n = s_dat[7:0];
          end else begin
            start_n = 1'b1;
            chan_n = s_dat[7:0];
          end
          state_n = RX_FRAME;
        end
        esc_cmd: begin
          lrst_n = (s_dat[7:0] == RASPI_CMD_RESET);
          dbg_n = (s_dat[7:0] == RASPI_CMD_DEBUG);
          state_n = RX_IDLE;
        end
        frame_dat: begin
          valid_n = 1'b1;
          data_n = s_dat[7:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= RX_IDLE;
      pend_start <= 1'b0;
      pend_chan <= '0;
      rx_start <= 1'b0;
      rx_end <= 1'b0;
      rx_valid <= 1'b0;
      link_reset <= 1'b0;
      dbg_req <= 1'b0;
      rx_chan <= '0;
      rx_data <= '0;
    end else begin
      state <= state_n;
      pend_start <= pend_n;
      pend_chan <= pchan_n;
      rx_start <= start_n;
      rx_end <= end_n;
      rx_valid <= valid_n;
      link_reset <= lrst_n;
      dbg_req <= dbg_n;
      rx_chan <= chan_n;
      rx_data <= data_n;
    end
  end

  logic [RASPI_WORD_W-1:0] tx_head;
  logic tx_full, tx_empty;

  raspi_link_fifo #(
    .WIDTH(RASPI_WORD_W),
    .DEPTH(TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .resetn(resetn),
    .flush (link_reset),
    .push  (tx_valid),
    .pop   (rd_evt),
    .din   (tx_data),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign tx_ready = !tx_full;
  assign raspi_dat_o = tx_empty ? RASPI_ESC : tx_head;

`ifdef RASPI_LINK_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_words <= '0;
      tx_words <= '0;
    end else if (link_reset) begin
      rx_words <= '0;
      tx_words <= '0;
    end else begin
      if (wr_evt) rx_words <= rx_words + 16'd1;
      if (rd_evt && !tx_empty) tx_words <= tx_words + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_raspi_link_endpoint.sv
// Scoreboard bench for raspi_link_endpoint: directed host writes/reads
// and TX pushes; monitors compare strobes and host read words.
module tb_raspi_link_endpoint;
  localparam int K_START = 0;
  localparam int K_VALID = 1;
  localparam int K_END = 2;
  localparam int K_LRST = 3;
  localparam int K_DBG = 4;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] chan;
    logic [7:0] data;
    logic       consec;
  } ev_t;

  logic       clk = 0;
  logic       resetn = 0;
  logic       raspi_clk = 0;
  logic       raspi_dir = 1;
  logic [8:0] raspi_dat_i = '0;
  logic [8:0] raspi_dat_o;
  logic       raspi_dat_oe;
  logic       rx_valid, rx_start, rx_end;
  logic [7:0] rx_chan, rx_data;
  logic       link_reset, dbg_req;
  logic       tx_valid = 0;
  logic       tx_ready;
  logic [8:0] tx_data = '0;
`ifdef RASPI_LINK_STATS_EN
  logic [15:0] rx_words, tx_words;
  logic [15:0] rx_base;
`endif

  raspi_link_endpoint #(.TX_DEPTH(16), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .raspi_clk   (raspi_clk),
    .raspi_dir   (raspi_dir),
    .raspi_dat_i (raspi_dat_i),
    .raspi_dat_o (raspi_dat_o),
    .raspi_dat_oe(raspi_dat_oe),
    .rx_valid    (rx_valid),
    .rx_start    (rx_start),
    .rx_end      (rx_end),
    .rx_chan     (rx_chan),
    .rx_data     (rx_data),
    .link_reset  (link_reset),
    .dbg_req     (dbg_req),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data)
`ifdef RASPI_LINK_STATS_EN
    ,
    .rx_words    (rx_words),
    .tx_words    (tx_words)
`endif
  );

  always #5 clk = ~clk;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   last_end = -100;
  ev_t  ev_q[$];
  logic [8:0] tx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic exp_ev(input int kind, input logic [7:0] chan,
                        input logic [7:0] data, input logic consec);
    ev_t e;
    e.kind = 3'(kind);
    e.chan = chan;
    e.data = data;
    e.consec = consec;
    ev_q.push_back(e);
  endtask

  task automatic obs(input int kind, input logic [7:0] chan,
                     input logic [7:0] data);
    ev_t o;
    o.kind = 3'(kind);
    o.chan = chan;
    o.data = data;
    o.consec = (kind == K_START) && (cyc - last_end == 1);
    if (kind == K_END) last_end = cyc;
    if (ev_q.size() == 0) begin
      total_cnt++;
      $display("FAIL unexpected_strobe: got %h expected none", o);
    end else begin
      chk("rx_event", o, ev_q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (rx_end) obs(K_END, rx_chan, 8'h00);
      if (rx_start) obs(K_START, rx_chan, 8'h00);
      if (rx_valid) obs(K_VALID, rx_chan, rx_data);
      if (link_reset) obs(K_LRST, 8'h00, 8'h00);
      if (dbg_req) obs(K_DBG, 8'h00, 8'h00);
    end
  end

  always @(posedge raspi_clk) begin
    if (!raspi_dir) begin
      chk("read_oe", raspi_dat_oe, 1'b1);
      if (tx_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_read: got %h expected none", raspi_dat_o);
      end else begin
        chk("read_word", raspi_dat_o, tx_q.pop_front());
      end
    end
  end

  task automatic host_write(input logic [8:0] w);
    @(negedge clk);
    raspi_dir = 1'b1;
    raspi_dat_i = w;
    repeat (6) @(negedge clk);
    raspi_clk = 1'b1;
    repeat (6) @(negedge clk);
    raspi_clk = 1'b0;
  endtask

  task automatic host_read(input logic [8:0] exp);
    tx_q.push_back(exp);
    @(negedge clk);
    raspi_dir = 1'b0;
    repeat (6) @(negedge clk);
    raspi_clk = 1'b1;
    repeat (6) @(negedge clk);
    raspi_clk = 1'b0;
  endtask

  task automatic push(input logic [8:0] w);
    int n;
    n = 0;
    @(negedge clk);
    tx_data = w;
    tx_valid = 1'b1;
    while (!tx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) chk("push_ready_timeout", tx_ready, 1'b1);
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_oe", raspi_dat_oe, 1'b0);
    chk("rst_dat_o", raspi_dat_o, 9'h1ff);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_strobes", {rx_valid, rx_start, rx_end, link_reset, dbg_req}, 5'b0);
    chk("rst_chan_data", {rx_chan, rx_data}, 16'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_state();
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // reset mid-frame drops the frame and the queued word
    exp_ev(K_START, 8'h00, 8'h00, 1'b0);
    exp_ev(K_VALID, 8'h00, 8'h40, 1'b0);
    host_write(9'h100);
    host_write(9'h040);
    push(9'h0aa);
    @(negedge clk);
    resetn = 1'b0;
    #1 chk_reset_state();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    host_write(9'h041);

    // plain frame
    exp_ev(K_START, 8'h00, 8'h00, 1'b0);
    exp_ev(K_VALID, 8'h00, 8'h40, 1'b0);
    exp_ev(K_VALID, 8'h00, 8'h41, 1'b0);
    exp_ev(K_END, 8'h00, 8'h00, 1'b0);
    host_write(9'h100);
    host_write(9'h040);
    host_write(9'h041);
    host_write(9'h1ff);

    // channel switch: end and start on consecutive clocks
    exp_ev(K_START, 8'h00, 8'h00, 1'b0);
    exp_ev(K_VALID, 8'h00, 8'h55, 1'b0);
    exp_ev(K_END, 8'h00, 8'h00, 1'b0);
    exp_ev(K_START, 8'h01, 8'h00, 1'b1);
    host_write(9'h100);
    host_write(9'h055);
    host_write(9'h101);

    // link reset from inside a frame flushes queued TX words
    push(9'h011);
    push(9'h012);
    exp_ev(K_END, 8'h01, 8'h00, 1'b0);
    exp_ev(K_LRST, 8'h00, 8'h00, 1'b0);
    host_write(9'h1ff);
    host_write(9'h0ff);
    host_read(9'h1ff);
    host_read(9'h1ff);

    // unknown escape command and idle data are dropped
    host_write(9'h1ff);
    host_write(9'h055);
    host_write(9'h042);

    // debug request
`ifdef RASPI_LINK_STATS_EN
    rx_base = rx_words;
`endif
    exp_ev(K_DBG, 8'h00, 8'h00, 1'b0);
    host_write(9'h1ff);
    host_write(9'h000);
`ifdef RASPI_LINK_STATS_EN
    repeat (3) @(negedge clk);
    chk("stats_rx_words", rx_words, rx_base + 16'd2);
`endif

    // TX order with a trailing idle read
    push(9'h100);
    push(9'h0a1);
    push(9'h1ff);
    host_read(9'h100);
    host_read(9'h0a1);
    host_read(9'h1ff);
    host_read(9'h1ff);
`ifdef RASPI_LINK_STATS_EN
    chk("stats_tx_words", tx_words, 16'd3);
`endif

    // fill to full, free one slot by reading, then drain
    for (int i = 0; i < 16; i++) push(9'(i));
    @(negedge clk);
    chk("full_tx_ready", tx_ready, 1'b0);
    fork
      push(9'h010);
      host_read(9'h000);
    join
    @(negedge clk);
    chk("refull_tx_ready", tx_ready, 1'b0);
    for (int i = 1; i <= 16; i++) host_read(9'(i));
    host_read(9'h1ff);
    @(negedge clk);
    chk("drained_tx_ready", tx_ready, 1'b1);

    repeat (20) @(negedge clk);
    chk("pending_rx_events", ev_q.size(), 0);
    chk("pending_reads", tx_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
